// File: rtl/tdm_pkg.sv
// Shared types for the four-slot TDM lane: slot index, slot count and the
// frame-alignment state used by the receive-side demultiplexer.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Two-bit wrapping slot counter shared by the TDM mux sequencer and demux.
// Priority: clr, then load0 (slot 0 consumed, next is 1), then inc.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load0,
    input  logic  inc,
    output slot_t slot
);

    slot_t slot_reg;
    slot_t slot_next;

    always_comb begin
        slot_next = slot_reg;
        if (clr) begin
            slot_next = '0;
        end else if (load0) begin
            slot_next = slot_t'(1);
        end else if (inc) begin
            slot_next = slot_reg + slot_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot = slot_reg;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: realigns on SYNC, collects slots A..D and
// updates all four channel outputs together once per complete frame.
// Optional build macro TDM_DEMUX4_STRICT_SYNC_EN: require SYNC on every slot 0.
module tdm_demux4
    import tdm_pkg::NUM_SLOTS, tdm_pkg::slot_t, tdm_pkg::state_t, tdm_pkg::HUNT;
#(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] DIN,
    input  logic         VIN,
    input  logic         SYNC,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic [W-1:0] D,
    output logic         FRAME_VLD,
    output logic [1:0]   SLOT,
    output logic         LOCKED,
    output logic         SYNC_ERR
);

    state_t       state_reg;
    state_t       state_next;
    slot_t        slot;
    logic         ctr_clr;
    logic         ctr_load0;
    logic         ctr_inc;
    logic         shadow_we;
    slot_t        wr_idx;
    logic         frame_done;
    logic         sync_err_next;

    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] c_reg;
    logic [W-1:0] d_reg;
    logic         frame_vld_reg;
    logic         sync_err_reg;

    tdm_slot_ctr u_slot_ctr (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (ctr_clr),
        .load0 (ctr_load0),
        .inc   (ctr_inc),
        .slot  (slot)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ctr_clr       = 1'b0;
        ctr_load0     = 1'b0;
        ctr_inc       = 1'b0;
        shadow_we     = 1'b0;
        wr_idx        = slot;
        frame_done    = 1'b0;
        sync_err_next = 1'b0;
        if (VIN) begin
            if (state_reg == HUNT) begin
                if (SYNC) begin
                    shadow_we  = 1'b1;
                    wr_idx     = '0;
                    ctr_load0  = 1'b1;
                    state_next = tdm_pkg::LOCKED;
                end
            end else if (SYNC && slot != '0) begin
                // Early marker: drop the partial frame and restart at slot 0.
                sync_err_next = 1'b1;
                shadow_we     = 1'b1;
                wr_idx        = '0;
                ctr_load0     = 1'b1;
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
            end else if (!SYNC && slot == '0) begin
                sync_err_next = 1'b1;
                ctr_clr       = 1'b1;
                state_next    = HUNT;
`endif
            end else begin
                shadow_we  = 1'b1;
                ctr_inc    = 1'b1;
                frame_done = (slot == slot_t'(NUM_SLOTS - 1));
            end
        end
    end

    // Slot 3 never needs storage: it goes straight to D on completion.
    for (genvar gi = 0; gi < NUM_SLOTS - 1; gi++) begin : g_shadow
        logic [W-1:0] data_reg;
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                data_reg <= '0;
            end else if (shadow_we && wr_idx == slot_t'(gi)) begin
                data_reg <= DIN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= '0;
            d_reg         <= '0;
            frame_vld_reg <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            frame_vld_reg <= frame_done;
            sync_err_reg  <= sync_err_next;
            if (frame_done) begin
                a_reg <= g_shadow[0].data_reg;
                b_reg <= g_shadow[1].data_reg;
                c_reg <= g_shadow[2].data_reg;
                d_reg <= DIN;
            end
        end
    end

    assign A         = a_reg;
    assign B         = b_reg;
    assign C         = c_reg;
    assign D         = d_reg;
    assign FRAME_VLD = frame_vld_reg;
    assign SLOT      = slot;
    assign LOCKED    = (state_reg == tdm_pkg::LOCKED);
    assign SYNC_ERR  = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (W=8): directed frame scenarios plus random lane traffic,
// every cycle checked against a per-sample reference of the framing rules.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         VIN = 1'b0;
    logic         SYNC = 1'b0;
    logic [W-1:0] A, B, C, D;
    logic         FRAME_VLD;
    logic [1:0]   SLOT;
    logic         LOCKED;
    logic         SYNC_ERR;

    int vectors = 0;
    int miscompares = 0;

    tdm_demux4 #(.W(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .VIN       (VIN),
        .SYNC      (SYNC),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .FRAME_VLD (FRAME_VLD),
        .SLOT      (SLOT),
        .LOCKED    (LOCKED),
        .SYNC_ERR  (SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    logic [36:0] obs;
    assign obs = {A, B, C, D, FRAME_VLD, SLOT, LOCKED, SYNC_ERR};

    // Reference: framing rules applied one accepted sample at a time.
    bit       m_locked;
    int       m_slot;
    logic [7:0] m_sh [4];
    logic [7:0] m_out [4];
    logic     m_fv;
    logic     m_err;

    function automatic logic [36:0] exp_vec();
        logic [1:0] s;
        s = 2'(m_slot);
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_fv, s, m_locked, m_err};
    endfunction

    task automatic model_step(input logic rn, input logic v, input logic s, input logic [7:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!rn) begin
            m_locked = 1'b0;
            m_slot   = 0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i]  = '0;
                m_out[i] = '0;
            end
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_sh[0]  = d;
                    m_slot   = 1;
                    m_locked = 1'b1;
                end
            end else if (s && m_slot != 0) begin
                m_err   = 1'b1;
                m_sh[0] = d;
                m_slot  = 1;
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
            end else if (!s && m_slot == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
                m_slot   = 0;
`endif
            end else begin
                m_sh[m_slot] = d;
                if (m_slot == 3) begin
                    m_out = m_sh;
                    m_fv  = 1'b1;
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
    endtask

    task automatic apply(input logic rn, input logic v, input logic s, input logic [7:0] d);
        RST_N = rn;
        VIN   = v;
        SYNC  = s;
        DIN   = d;
        @(posedge CLK);
        model_step(rn, v, s, d);
        #1;
        if (FRAME_VLD === 1'b1)
            $display("frame A=%h B=%h C=%h D=%h at %0t", A, B, C, D, $time);
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        apply(1'b0, 1'b1, 1'b1, 8'hFF);
        vectors++;
        if (obs !== 37'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, 37'h0);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, i == 0, d[i]);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_slot%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if ({A, B, C, D, FRAME_VLD, LOCKED, SLOT} !== {32'h11223344, 1'b1, 1'b1, 2'b00}) begin
            miscompares++;
            $display("FAIL basic_frame: got %h%h%h%h vld=%b lk=%b slot=%0d expected 11223344 vld=1 lk=1 slot=0",
                     A, B, C, D, FRAME_VLD, LOCKED, SLOT);
        end
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (FRAME_VLD !== 1'b0 || {A, B, C, D} !== 32'h11223344) begin
            miscompares++;
            $display("FAIL basic_pulse_end: got vld=%b data=%h%h%h%h expected vld=0 data=11223344",
                     FRAME_VLD, A, B, C, D);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int pulses = 0;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, i == 0, d[i]);
            if (FRAME_VLD === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL gaps_slot%0d: got %h expected %h", i, obs, exp_vec());
            end
            for (int g = 0; g < i; g++) begin
                apply(1'b1, 1'b0, $urandom_range(0, 1), 8'($urandom));
                if (FRAME_VLD === 1'b1) pulses++;
                vectors++;
                if (obs !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL gaps_idle%0d: got %h expected %h", i, obs, exp_vec());
                end
            end
        end
        vectors++;
        if (pulses != 1 || {A, B, C, D} !== 32'h11223344) begin
            miscompares++;
            $display("FAIL gaps_frame: got pulses=%0d data=%h%h%h%h expected pulses=1 data=11223344",
                     pulses, A, B, C, D);
        end
    endtask

    task automatic test_early_sync();
        logic [7:0] d [6] = '{8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic       s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int pulses = 0;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, s[i], d[i]);
            if (i < 5 && FRAME_VLD === 1'b1) pulses++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL early_step%0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 2) begin
                vectors++;
                if (SYNC_ERR !== 1'b1 || LOCKED !== 1'b1 || SLOT !== 2'd1) begin
                    miscompares++;
                    $display("FAIL early_err: got err=%b lk=%b slot=%0d expected err=1 lk=1 slot=1",
                             SYNC_ERR, LOCKED, SLOT);
                end
            end
        end
        vectors++;
        if (pulses != 0 || FRAME_VLD !== 1'b1 || {A, B, C, D} !== 32'hAABBCCDD) begin
            miscompares++;
            $display("FAIL early_frame: got early_pulses=%0d vld=%b data=%h%h%h%h expected 0 1 AABBCCDD",
                     pulses, FRAME_VLD, A, B, C, D);
        end
    endtask

    task automatic test_hunt_ignore();
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        apply(1'b1, 1'b1, 1'b0, 8'h55);
        apply(1'b1, 1'b1, 1'b0, 8'h66);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL hunt_model: got %h expected %h", obs, exp_vec());
        end
        vectors++;
        if (SLOT !== 2'd0 || LOCKED !== 1'b0 || {A, B, C, D} !== 32'h0) begin
            miscompares++;
            $display("FAIL hunt_ignore: got slot=%0d lk=%b data=%h%h%h%h expected slot=0 lk=0 data=0",
                     SLOT, LOCKED, A, B, C, D);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] d2 [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, i == 0, d1[i]);
        apply(1'b1, 1'b1, 1'b1, 8'hE1);
        apply(1'b1, 1'b1, 1'b0, 8'hE2);
        apply(1'b0, 1'b1, 1'b0, 8'hE3);
        vectors++;
        if (obs !== 37'h0) begin
            miscompares++;
            $display("FAIL midframe_reset: got %h expected %h", obs, 37'h0);
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, i == 0, d2[i]);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL midframe_slot%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if ({A, B, C, D} !== 32'h5A6B7C8D || FRAME_VLD !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_frame: got %h%h%h%h vld=%b expected 5A6B7C8D vld=1",
                     A, B, C, D, FRAME_VLD);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int pulses = 0;
        int errs = 0;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, i == 0, d[i]);
            if (FRAME_VLD === 1'b1) pulses++;
            if (SYNC_ERR === 1'b1) errs++;
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_slot%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
        if (pulses != 1 || errs != 1 || LOCKED !== 1'b0 || {A, B, C, D} !== 32'h11223344) begin
            miscompares++;
            $display("FAIL b2b_strict: got pulses=%0d errs=%0d lk=%b data=%h%h%h%h expected 1 1 0 11223344",
                     pulses, errs, LOCKED, A, B, C, D);
        end
`else
        if (pulses != 2 || errs != 0 || LOCKED !== 1'b1 || {A, B, C, D} !== 32'h55667788) begin
            miscompares++;
            $display("FAIL b2b_flywheel: got pulses=%0d errs=%0d lk=%b data=%h%h%h%h expected 2 0 1 55667788",
                     pulses, errs, LOCKED, A, B, C, D);
        end
`endif
    endtask

    task automatic test_random();
        logic rn, v, s;
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            rn = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 9) < 7);
            s  = (m_slot == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            apply(rn, v, s, 8'($urandom));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_early_sync();
        test_hunt_ignore();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
